// File: rtl/emg_spike_counter_if.sv
// Spike counter bus: run control and spike lines in, windowed count out.
interface emg_spike_counter_if #(
  parameter int N_LANES = 32,
  parameter int CNT_W   = 32,
  parameter int WIN_W   = 16
);
  logic               enable;
  logic [WIN_W-1:0]   window_len;
  logic [N_LANES-1:0] spike_in;
  logic [CNT_W-1:0]   spike_cnt;
  logic               cnt_valid;
  logic               cnt_sat;
  logic [15:0]        win_idx;

  modport master (output enable, window_len, spike_in,
                  input  spike_cnt, cnt_valid, cnt_sat, win_idx);
  modport slave  (input  enable, window_len, spike_in,
                  output spike_cnt, cnt_valid, cnt_sat, win_idx);
endinterface

// File: rtl/emg_spike_counter.sv
// Windowed rising-edge counter across N_LANES spike lines. One count and a
// one-cycle strobe per window of W enabled samples; no backpressure.
module emg_spike_counter #(
  parameter int N_LANES = 32,
  parameter int CNT_W   = 32,
  parameter int WIN_W   = 16
) (
  input logic clk,
  input logic reset,
  emg_spike_counter_if.slave bus
);
  localparam int INC_W = $clog2(N_LANES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [N_LANES-1:0] prev_q, rise;
  logic [INC_W-1:0]   inc;
  logic [CNT_W-1:0]   acc_q, acc_d, acc_eff, sum_sat;
  logic [CNT_W:0]     sum;
  logic               ovf, sat_q, sat_d, sat_eff;
  logic [WIN_W-1:0]   pos_q, pos_d, pos_eff, w_q, w_d, w_eff, wlen_eff;
  logic               close;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               csat_q, csat_d, vld_q, vld_d;
  logic [15:0]        idx_q, idx_d;

  // Per-lane 0->1 detection against last cycle's sample.
  assign rise = bus.spike_in & ~prev_q;

  // Number of lanes that rose this cycle.
  always_comb begin
    inc = '0;
    for (int i = 0; i < N_LANES; i++) inc = inc + INC_W'(rise[i]);
  end

  // In IDLE the window being opened starts from an empty accumulator, so the
  // first enabled sample is handled by the same close/accumulate path as RUN.
  assign wlen_eff = (bus.window_len == '0) ? WIN_W'(1) : bus.window_len;
  assign acc_eff  = (state_q == IDLE) ? '0 : acc_q;
  assign pos_eff  = (state_q == IDLE) ? '0 : pos_q;
  assign w_eff    = (state_q == IDLE) ? wlen_eff : w_q;
  assign sat_eff  = (state_q == IDLE) ? 1'b0 : sat_q;
  assign sum      = {1'b0, acc_eff} + (CNT_W+1)'(inc);
  assign ovf      = sum[CNT_W];
  assign sum_sat  = ovf ? '1 : sum[CNT_W-1:0];
  assign close    = bus.enable && (pos_eff == w_eff - WIN_W'(1));

  // Next-state: accumulate, close a window, or fall back to IDLE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    pos_d   = pos_q;
    w_d     = w_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    csat_d  = csat_q;
    idx_d   = idx_q;
    vld_d   = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
      acc_d   = '0;
      pos_d   = '0;
      sat_d   = 1'b0;
    end else begin
      state_d = RUN;
      if (close) begin
        cnt_d  = sum_sat;
        csat_d = sat_eff | ovf;
        vld_d  = 1'b1;
        idx_d  = idx_q + 16'd1;
        acc_d  = '0;
        pos_d  = '0;
        sat_d  = 1'b0;
        w_d    = wlen_eff;   // next window starts next cycle with this length
      end else begin
        acc_d  = sum_sat;
        pos_d  = pos_eff + WIN_W'(1);
        sat_d  = sat_eff | ovf;
        w_d    = w_eff;
      end
    end
  end

  // State and output registers; prev samples every cycle regardless of enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q  <= '0;
      acc_q   <= '0;
      pos_q   <= '0;
      w_q     <= WIN_W'(1);
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      csat_q  <= 1'b0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= bus.spike_in;
      acc_q   <= acc_d;
      pos_q   <= pos_d;
      w_q     <= w_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      csat_q  <= csat_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.spike_cnt = cnt_q;
  assign bus.cnt_sat   = csat_q;
  assign bus.cnt_valid = vld_q;
  assign bus.win_idx   = idx_q;
endmodule

// File: tb/tb_emg_spike_counter.sv
// Bench for emg_spike_counter: a 32-bit and an 8-bit count instance share
// stimulus and are checked against a window-list reference model.
module tb_emg_spike_counter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  emg_spike_counter_if #(.N_LANES(32), .CNT_W(32), .WIN_W(16)) if32();
  emg_spike_counter_if #(.N_LANES(32), .CNT_W(8),  .WIN_W(16)) if8();

  emg_spike_counter #(.N_LANES(32), .CNT_W(32), .WIN_W(16)) dut32 (
    .clk(clk), .reset(reset), .bus(if32));
  emg_spike_counter #(.N_LANES(32), .CNT_W(8), .WIN_W(16)) dut8 (
    .clk(clk), .reset(reset), .bus(if8));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: list of per-sample edge counts for the open window.
  logic [31:0] m_prev;
  bit          m_run;
  int          m_w;
  int          q_inc[$];
  longint      m_total;
  bit          m_valid;
  int          m_idx;
  logic [49:0] m_exp32;
  logic [25:0] m_exp8;

  function automatic void model_outputs();
    logic [31:0] c32;
    logic [7:0]  c8;
    bit s32, s8;
    s32 = (m_total > 64'hFFFF_FFFF);
    c32 = s32 ? 32'hFFFF_FFFF : m_total[31:0];
    s8  = (m_total > 255);
    c8  = s8 ? 8'hFF : m_total[7:0];
    m_exp32 = {m_valid, s32, m_idx[15:0], c32};
    m_exp8  = {m_valid, s8,  m_idx[15:0], c8};
  endfunction

  function automatic void model_reset();
    m_prev = '0; m_run = 0; q_inc.delete(); m_total = 0;
    m_valid = 0; m_idx = 0; m_w = 1;
    model_outputs();
  endfunction

  function automatic void model_step(bit en, int wl, logic [31:0] sp);
    int inc;
    inc = $countones(sp & ~m_prev);
    m_prev = sp;
    m_valid = 0;
    if (!en) begin
      m_run = 0;
      q_inc.delete();
    end else begin
      if (!m_run) begin m_run = 1; m_w = (wl == 0) ? 1 : wl; end
      q_inc.push_back(inc);
      if (q_inc.size() == m_w) begin
        m_total = 0;
        foreach (q_inc[k]) m_total += q_inc[k];
        m_valid = 1;
        m_idx = (m_idx + 1) % 65536;
        q_inc.delete();
        m_w = (wl == 0) ? 1 : wl;
      end
    end
    model_outputs();
  endfunction

  // Called at a negedge: drive inputs, clock once, step model, return at negedge.
  task automatic tick(input bit en, input int wl, input logic [31:0] sp);
    if32.enable = en; if32.window_len = 16'(wl); if32.spike_in = sp;
    if8.enable  = en; if8.window_len  = 16'(wl); if8.spike_in  = sp;
    @(posedge clk);
    model_step(en, wl, sp);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(0, 0, '0);
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if32.enable = 0; if32.window_len = 0; if32.spike_in = '0;
    if8.enable = 0;  if8.window_len = 0;  if8.spike_in = '0;
    @(negedge clk); @(negedge clk);
    model_reset();
    n_tests++;
    if ({if32.cnt_valid, if32.cnt_sat, if32.win_idx, if32.spike_cnt} !== 50'd0) begin
      n_fail++; $display("FAIL reset32: got %h exp 0",
        {if32.cnt_valid, if32.cnt_sat, if32.win_idx, if32.spike_cnt});
    end
    n_tests++;
    if ({if8.cnt_valid, if8.cnt_sat, if8.win_idx, if8.spike_cnt} !== 26'd0) begin
      n_fail++; $display("FAIL reset8: got %h exp 0",
        {if8.cnt_valid, if8.cnt_sat, if8.win_idx, if8.spike_cnt});
    end
    reset = 1'b0;
  endtask

  task automatic test_single_pulse();
    logic [31:0] sp;
    for (int c = 0; c < 12; c++) begin
      sp = (c >= 2 && c <= 5) ? 32'h8 : 32'h0;
      tick(1, 10, sp);
      n_tests++;
      if ({if32.cnt_valid, if32.cnt_sat, if32.win_idx, if32.spike_cnt} !== m_exp32) begin
        n_fail++; $display("FAIL single_pulse c=%0d: got %h exp %h", c,
          {if32.cnt_valid, if32.cnt_sat, if32.win_idx, if32.spike_cnt}, m_exp32);
      end
      if (c == 9) begin
        n_tests++;
        if (if32.spike_cnt !== 32'd1 || if32.cnt_valid !== 1'b1 ||
            if32.win_idx !== 16'd1 || if32.cnt_sat !== 1'b0) begin
          n_fail++; $display("FAIL single_pulse_close: cnt=%0d vld=%b idx=%0d sat=%b exp 1/1/1/0",
            if32.spike_cnt, if32.cnt_valid, if32.win_idx, if32.cnt_sat);
        end
      end
      if (c == 10) begin
        n_tests++;
        if (if32.cnt_valid !== 1'b0) begin
          n_fail++; $display("FAIL single_pulse_strobe_len: got vld=%b exp 0", if32.cnt_valid);
        end
      end
    end
  endtask

  task automatic test_toggle();
    int last, nstrobe;
    last = -1; nstrobe = 0;
    tick(0, 8, '0);
    for (int c = 0; c < 40; c++) begin
      tick(1, 8, (c % 2 == 0) ? 32'hFFFF_FFFF : 32'h0);
      n_tests++;
      if ({if32.cnt_valid, if32.cnt_sat, if32.win_idx, if32.spike_cnt} !== m_exp32) begin
        n_fail++; $display("FAIL toggle c=%0d: got %h exp %h", c,
          {if32.cnt_valid, if32.cnt_sat, if32.win_idx, if32.spike_cnt}, m_exp32);
      end
      if (if32.cnt_valid) begin
        nstrobe++;
        n_tests++;
        if (if32.spike_cnt !== 32'd128 || (last >= 0 && c - last != 8)) begin
          n_fail++; $display("FAIL toggle_cadence c=%0d: cnt=%0d gap=%0d exp 128 gap 8",
            c, if32.spike_cnt, c - last);
        end
        last = c;
      end
    end
    n_tests++;
    if (nstrobe != 5) begin
      n_fail++; $display("FAIL toggle_strobes: got %0d exp 5", nstrobe);
    end
  endtask

  task automatic test_saturation();
    tick(0, 100, '0);
    for (int c = 0; c < 102; c++) begin
      tick(1, (c < 50) ? 100 : 2, (c < 100 && c % 2 == 0) ? 32'hFFFF_FFFF : 32'h0);
      n_tests++;
      if ({if8.cnt_valid, if8.cnt_sat, if8.win_idx, if8.spike_cnt} !== m_exp8 ||
          {if32.cnt_valid, if32.cnt_sat, if32.win_idx, if32.spike_cnt} !== m_exp32) begin
        n_fail++; $display("FAIL sat c=%0d: got8 %h exp8 %h got32 %h exp32 %h", c,
          {if8.cnt_valid, if8.cnt_sat, if8.win_idx, if8.spike_cnt}, m_exp8,
          {if32.cnt_valid, if32.cnt_sat, if32.win_idx, if32.spike_cnt}, m_exp32);
      end
      if (c == 99) begin
        n_tests++;
        if (if8.spike_cnt !== 8'd255 || if8.cnt_sat !== 1'b1 || if8.cnt_valid !== 1'b1 ||
            if32.spike_cnt !== 32'd1600 || if32.cnt_sat !== 1'b0) begin
          n_fail++; $display("FAIL sat_clamp: cnt8=%0d sat8=%b cnt32=%0d sat32=%b exp 255/1/1600/0",
            if8.spike_cnt, if8.cnt_sat, if32.spike_cnt, if32.cnt_sat);
        end
      end
      if (c == 101) begin
        n_tests++;
        if (if8.spike_cnt !== 8'd0 || if8.cnt_sat !== 1'b0 || if8.cnt_valid !== 1'b1) begin
          n_fail++; $display("FAIL sat_clear: cnt8=%0d sat8=%b vld=%b exp 0/0/1",
            if8.spike_cnt, if8.cnt_sat, if8.cnt_valid);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [31:0] sp;
    bit en;
    int wl;
    tick(0, 5, '0);
    // c 0..4: 5-cycle window with two spikes; c 5..9: pos 0..4 of a 10-window
    // with three spikes; c 10: enable low (pos 5); c 11..24 idle; then re-enable.
    for (int c = 0; c < 30; c++) begin
      sp = 32'h0; en = 1; wl = (c < 4) ? 5 : 10;
      if (c == 1) sp = 32'h60;
      if (c == 5) sp = 32'h1;
      if (c == 7) sp = 32'h2;
      if (c == 9) sp = 32'h4;
      if (c >= 10 && c < 25) en = 0;
      if (c >= 25) wl = 4;
      if (c == 26) sp = 32'h80;
      tick(en, wl, sp);
      n_tests++;
      if ({if32.cnt_valid, if32.cnt_sat, if32.win_idx, if32.spike_cnt} !== m_exp32) begin
        n_fail++; $display("FAIL en_drop c=%0d: got %h exp %h", c,
          {if32.cnt_valid, if32.cnt_sat, if32.win_idx, if32.spike_cnt}, m_exp32);
      end
      if (c >= 10 && c < 25) begin
        n_tests++;
        if (if32.cnt_valid !== 1'b0 || if32.spike_cnt !== 32'd2) begin
          n_fail++; $display("FAIL en_drop_hold c=%0d: vld=%b cnt=%0d exp 0/2",
            c, if32.cnt_valid, if32.spike_cnt);
        end
      end
      if (c == 28) begin
        n_tests++;
        if (if32.cnt_valid !== 1'b1 || if32.spike_cnt !== 32'd1) begin
          n_fail++; $display("FAIL en_drop_fresh: vld=%b cnt=%0d exp 1/1",
            if32.cnt_valid, if32.spike_cnt);
        end
      end
    end
  endtask

  task automatic test_window_change();
    int wl;
    bit exp_v;
    tick(0, 10, '0);
    for (int c = 0; c < 20; c++) begin
      wl = (c < 3) ? 10 : (c < 10) ? 4 : 0;
      tick(1, wl, $urandom());
      exp_v = (c == 9) || (c >= 13);
      n_tests++;
      if ({if32.cnt_valid, if32.cnt_sat, if32.win_idx, if32.spike_cnt} !== m_exp32 ||
          if32.cnt_valid !== exp_v) begin
        n_fail++; $display("FAIL win_change c=%0d: got %h exp %h vld_exp %b", c,
          {if32.cnt_valid, if32.cnt_sat, if32.win_idx, if32.spike_cnt}, m_exp32, exp_v);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tick(($urandom() % 8) != 0, $urandom_range(0, 6), $urandom());
      n_tests++;
      if ({if32.cnt_valid, if32.cnt_sat, if32.win_idx, if32.spike_cnt} !== m_exp32 ||
          {if8.cnt_valid, if8.cnt_sat, if8.win_idx, if8.spike_cnt} !== m_exp8) begin
        n_fail++; $display("FAIL random c=%0d: got32 %h exp32 %h got8 %h exp8 %h", c,
          {if32.cnt_valid, if32.cnt_sat, if32.win_idx, if32.spike_cnt}, m_exp32,
          {if8.cnt_valid, if8.cnt_sat, if8.win_idx, if8.spike_cnt}, m_exp8);
      end
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    for (int c = 0; c < 65536; c++) begin
      tick(1, 1, '0);
      if (c == 65534 || c == 65535) begin
        n_tests++;
        if (if32.win_idx !== ((c == 65534) ? 16'hFFFF : 16'h0000) ||
            if32.win_idx !== m_exp32[47:32] || if32.cnt_valid !== 1'b1) begin
          n_fail++; $display("FAIL wrap c=%0d: idx=%h vld=%b model_idx=%h",
            c, if32.win_idx, if32.cnt_valid, m_exp32[47:32]);
        end
      end
    end
    // Lane 0 high across a mid-window reset.
    tick(1, 10, '0);
    tick(1, 10, 32'h1);
    tick(1, 10, 32'h1);
    reset = 1'b1;
    #1;
    n_tests++;
    if ({if32.cnt_valid, if32.cnt_sat, if32.win_idx, if32.spike_cnt} !== 50'd0) begin
      n_fail++; $display("FAIL reset_async: got %h exp 0",
        {if32.cnt_valid, if32.cnt_sat, if32.win_idx, if32.spike_cnt});
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick(1, 3, 32'h1);
      n_tests++;
      if ({if32.cnt_valid, if32.cnt_sat, if32.win_idx, if32.spike_cnt} !== m_exp32) begin
        n_fail++; $display("FAIL post_reset c=%0d: got %h exp %h", c,
          {if32.cnt_valid, if32.cnt_sat, if32.win_idx, if32.spike_cnt}, m_exp32);
      end
      if (c == 2) begin
        n_tests++;
        if (if32.spike_cnt !== 32'd1 || if32.cnt_valid !== 1'b1 || if32.win_idx !== 16'd1) begin
          n_fail++; $display("FAIL post_reset_once: cnt=%0d vld=%b idx=%0d exp 1/1/1",
            if32.spike_cnt, if32.cnt_valid, if32.win_idx);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_pulse();
    test_toggle();
    test_saturation();
    test_enable_drop();
    test_window_change();
    test_random();
    test_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Overall time guard so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: sim exceeded time budget at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
